// File: rtl/bank_cmd_multi_pkg.sv
// bank_cmd_multi_pkg: command and task ICD packages shared by the bank command handler
package cmd_icd_pkg;
  function automatic logic [31:0] task2bank_cmd(input logic [3:0] bank, input logic [7:0] val);
    return {16'hB4C0, 4'h0, bank, val};
  endfunction
endpackage

package task_icd_pkg;
  localparam int unsigned HEADER_BYTES = 16;
  localparam int unsigned BANK_CMD_WORDS = 2;
  localparam logic [31:0] TASK_VALID = 32'd1;
  localparam logic [31:0] HEADER_INVALID = 32'd2;
  localparam logic [31:0] PAYLOAD_INVALID = 32'd3;
  localparam logic [31:0] EXE_ERROR = 32'd4;
endpackage

// File: rtl/bank_cmd_multi_validator.sv
// bank_cmd_validator: length decode into a command limit and first out-of-range pair index
module bank_cmd_validator
  import task_icd_pkg::*;
#(
  parameter int unsigned MAX_CMDS = 8,
  parameter int unsigned BANK_MAX = 15,
  parameter int unsigned VAL_MAX = 255,
  localparam int CW = $clog2(MAX_CMDS + 1)
) (
  input  logic [31:0] len,
  input  logic [32*MAX_CMDS-1:0] bank,
  input  logic [32*MAX_CMDS-1:0] val,
  output logic len_ok,
  output logic [CW-1:0] n,
  output logic [CW-1:0] first_bad
);
  logic [31:0] d;
  always_comb begin
    d = len - HEADER_BYTES;
    len_ok = len >= HEADER_BYTES && d[2:0] == 3'd0 && d[31:3] != 29'd0 && d[31:3] <= 29'(MAX_CMDS);
    n = CW'(d[31:3]);
    // MAX_CMDS means no bad pair; the lowest bad index wins
    first_bad = CW'(MAX_CMDS);
    for (int i = int'(MAX_CMDS) - 1; i >= 0; i--)
      if (bank[32*i +: 32] > BANK_MAX || val[32*i +: 32] > VAL_MAX) first_bad = CW'(i);
  end
endmodule

// File: rtl/bank_cmd_multi.sv
// bank_cmd_multi: validates a multi-pair bank task and streams one command word per pair
// BANK_CMD_GAP_EN inserts GAP_CYCLES idle cycles between beats
module bank_cmd_multi
  import task_icd_pkg::*;
  import cmd_icd_pkg::*;
#(
  parameter int unsigned MAX_CMDS = 8,
  parameter int unsigned BANK_MAX = 15,
  parameter int unsigned VAL_MAX = 255,
  parameter int unsigned DEFAULT_TIMEOUT = 1000,
`ifdef BANK_CMD_GAP_EN
  parameter int unsigned GAP_CYCLES = 4,
`endif
  localparam int CW = $clog2(MAX_CMDS + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic task_valid,
  output logic task_ready,
  input  logic [31:0] len_bytes,
  input  logic [32*MAX_CMDS-1:0] bank_flat,
  input  logic [32*MAX_CMDS-1:0] val_flat,
  input  logic [31:0] timeout_limit,
  output logic resp_valid,
  output logic [31:0] resp,
  output logic [CW-1:0] resp_count,
  input  logic aso_cmd_ready,
  output logic aso_cmd_valid,
  output logic [31:0] aso_cmd_data
);
  localparam logic [2:0] IDLE = 3'd0, VLEN = 3'd1, VPAY = 3'd2, SRC = 3'd3;
`ifdef BANK_CMD_GAP_EN
  localparam logic [2:0] GAP = 3'd4;
  logic [31:0] gcnt;
`endif
  logic [2:0] st;
  logic [CW-1:0] idx, lim, n, first_bad, sel, fin_count;
  logic [31:0] len_q, tlim, cnt, word, fin_code;
  logic [32*MAX_CMDS-1:0] bank_q, val_q;
  logic len_ok, fin;
  bank_cmd_validator #(.MAX_CMDS(MAX_CMDS), .BANK_MAX(BANK_MAX), .VAL_MAX(VAL_MAX)) u_val (
    .len(len_q), .bank(bank_q), .val(val_q), .len_ok(len_ok), .n(n), .first_bad(first_bad)
  );
  // sel names the word to load next: word 0 on entry, idx+1 after a handshake, idx after a gap
  always_comb begin
    sel = st == SRC ? idx + CW'(1) : st == VPAY ? '0 : idx;
    word = '0;
    for (int i = 0; i < int'(MAX_CMDS); i++)
      if (CW'(i) == sel) word = task2bank_cmd(bank_q[32*i +: 4], val_q[32*i +: 8]);
    fin = (st == VLEN && !len_ok) || (st == VPAY && idx == first_bad) ||
          (st == SRC && (aso_cmd_ready ? idx == lim - CW'(1) : cnt + 32'd1 == tlim));
    fin_code = st == VLEN ? HEADER_INVALID : st == VPAY ? PAYLOAD_INVALID : aso_cmd_ready ? TASK_VALID : EXE_ERROR;
    fin_count = st != SRC ? '0 : aso_cmd_ready ? lim : idx;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      task_ready <= 1'b1;
      resp_valid <= 1'b0;
      resp <= '0;
      resp_count <= '0;
      aso_cmd_valid <= 1'b0;
      aso_cmd_data <= '0;
      idx <= '0;
      lim <= '0;
      cnt <= '0;
      tlim <= '0;
      len_q <= '0;
      bank_q <= '0;
      val_q <= '0;
`ifdef BANK_CMD_GAP_EN
      gcnt <= '0;
`endif
    end else begin
      resp_valid <= 1'b0;
      if (fin) begin
        st <= IDLE;
        task_ready <= 1'b1;
        resp_valid <= 1'b1;
        resp <= fin_code;
        resp_count <= fin_count;
        aso_cmd_valid <= 1'b0;
      end else
        case (st)
          IDLE: if (task_valid) begin
            st <= VLEN;
            task_ready <= 1'b0;
            len_q <= len_bytes;
            bank_q <= bank_flat;
            val_q <= val_flat;
            tlim <= timeout_limit == '0 ? DEFAULT_TIMEOUT : timeout_limit;
          end
          VLEN: begin
            st <= VPAY;
            lim <= n;
            idx <= '0;
          end
          VPAY: if (idx == lim - CW'(1)) begin
            st <= SRC;
            idx <= '0;
            cnt <= '0;
            aso_cmd_valid <= 1'b1;
            aso_cmd_data <= word;
          end else idx <= idx + CW'(1);
          SRC: if (aso_cmd_ready) begin
            cnt <= '0;
            idx <= idx + CW'(1);
`ifdef BANK_CMD_GAP_EN
            st <= GAP;
            gcnt <= '0;
            aso_cmd_valid <= 1'b0;
`else
            aso_cmd_data <= word;
`endif
          end else cnt <= cnt + 32'd1;
`ifdef BANK_CMD_GAP_EN
          GAP: if (gcnt == GAP_CYCLES - 1) begin
            st <= SRC;
            aso_cmd_valid <= 1'b1;
            aso_cmd_data <= word;
          end else gcnt <= gcnt + 32'd1;
`endif
          default: st <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_bank_cmd_multi.sv
// tb_bank_cmd_multi: randomized self-checking bench for bank_cmd_multi against a task-level model
module tb_bank_cmd_multi;
  import task_icd_pkg::*;
  localparam int MAXC = 8;
  localparam int CW = $clog2(MAXC + 1);
  logic clk = 1'b0, rst = 1'b1, task_valid = 1'b0, aso_cmd_ready = 1'b0;
  logic task_ready, resp_valid, aso_cmd_valid;
  logic [31:0] len_bytes = '0, timeout_limit = '0, resp, aso_cmd_data;
  logic [32*MAXC-1:0] bank_flat = '0, val_flat = '0;
  logic [CW-1:0] resp_count, r_count;
  int vectors = 0, errors = 0;
  logic [31:0] bk[MAXC], vl[MAXC];
  logic [31:0] exp_w[$], got[$];
  logic [31:0] exp_code, r_code;
  int exp_cnt, exp_bad, first_valid, resp_cyc, last_hs, stall_bad, ready_bad;

  bank_cmd_multi dut (
    .clk(clk), .rst(rst), .task_valid(task_valid), .task_ready(task_ready), .len_bytes(len_bytes),
    .bank_flat(bank_flat), .val_flat(val_flat), .timeout_limit(timeout_limit), .resp_valid(resp_valid),
    .resp(resp), .resp_count(resp_count), .aso_cmd_ready(aso_cmd_ready), .aso_cmd_valid(aso_cmd_valid),
    .aso_cmd_data(aso_cmd_data)
  );

  always #5 clk = ~clk;

  // Task-level reference: legality by arithmetic, first bad pair, expected word list
  task automatic model(input logic [31:0] len);
    logic [31:0] body, n;
    exp_w.delete();
    exp_bad = -1;
    body = len - HEADER_BYTES;
    n = body / 8;
    if (len < HEADER_BYTES || body % 8 != 0 || n < 1 || n > MAXC) begin
      exp_code = HEADER_INVALID;
      exp_cnt = 0;
      return;
    end
    for (int i = 0; i < int'(n); i++)
      if (bk[i] > 15 || vl[i] > 255) begin
        exp_code = PAYLOAD_INVALID;
        exp_cnt = 0;
        exp_bad = i;
        exp_w.delete();
        return;
      end else exp_w.push_back(cmd_icd_pkg::task2bank_cmd(bk[i][3:0], vl[i][7:0]));
    exp_code = TASK_VALID;
    exp_cnt = int'(n);
  endtask

  task automatic rand_pairs(input int bad_pct);
    for (int i = 0; i < MAXC; i++) begin
      bk[i] = ($urandom_range(0, 99) < bad_pct) ? $urandom_range(16, 40) : $urandom_range(0, 15);
      vl[i] = ($urandom_range(0, 99) < bad_pct) ? $urandom_range(256, 999) : $urandom_range(0, 255);
    end
  endtask

  task automatic send(input logic [31:0] len, input logic [31:0] tl);
    @(negedge clk);
    len_bytes = len;
    timeout_limit = tl;
    for (int i = 0; i < MAXC; i++) begin
      bank_flat[32*i +: 32] = bk[i];
      val_flat[32*i +: 32] = vl[i];
    end
    task_valid = 1'b1;
    @(posedge clk);
    #1 task_valid = 1'b0;
  endtask

  // Cycle 1 is the cycle after acceptance; mode 0 ready high, 1 random, 2 high until the first beat
  task automatic collect(input int mode, input int poke, input int budget);
    logic ps, r;
    logic [31:0] pd;
    got.delete();
    first_valid = -1;
    resp_cyc = -1;
    last_hs = -1;
    stall_bad = 0;
    ready_bad = 0;
    r_code = 32'hDEAD;
    r_count = '1;
    ps = 1'b0;
    pd = '0;
    for (int c = 1; c <= budget; c++) begin
      if (resp_valid) begin
        resp_cyc = c;
        r_code = resp;
        r_count = resp_count;
        aso_cmd_ready = 1'b0;
        task_valid = 1'b0;
        return;
      end
      if (task_ready) ready_bad++;
      if (aso_cmd_valid && first_valid < 0) first_valid = c;
      if (ps && aso_cmd_valid && aso_cmd_data !== pd) stall_bad++;
      r = (mode == 0) || (mode == 1 && $urandom_range(0, 1) == 1) || (mode == 2 && last_hs < 0);
      aso_cmd_ready = r;
      task_valid = (c == poke);
      if (aso_cmd_valid && r) begin
        got.push_back(aso_cmd_data);
        last_hs = c;
      end
      ps = aso_cmd_valid && !r;
      pd = aso_cmd_data;
      @(posedge clk);
      #1;
    end
    task_valid = 1'b0;
    aso_cmd_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({task_ready, resp_valid, resp, resp_count, aso_cmd_valid, aso_cmd_data} !== {1'b1, 1'b0, 32'd0, CW'(0), 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL reset_values got rdy=%0b rv=%0b resp=%0h cnt=%0d v=%0b d=%0h, want 1 0 0 0 0 0",
               task_ready, resp_valid, resp, resp_count, aso_cmd_valid, aso_cmd_data);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    bk[0] = 1;  vl[0] = 10;
    bk[1] = 2;  vl[1] = 20;
    bk[2] = 15; vl[2] = 255;
    for (int i = 3; i < MAXC; i++) begin bk[i] = 99; vl[i] = 999; end
    model(HEADER_BYTES + 24);
    send(HEADER_BYTES + 24, 0);
    collect(0, 0, 50);
    vectors++;
    if (r_code !== exp_code || r_count !== CW'(exp_cnt)) begin
      errors++; $display("FAIL nominal_resp got %0h/%0d want %0h/%0d", r_code, r_count, exp_code, exp_cnt);
    end
    vectors++;
    if (got.size() != exp_w.size()) begin
      errors++; $display("FAIL nominal_beats got %0d want %0d", got.size(), exp_w.size());
    end
    foreach (exp_w[i]) begin
      vectors++;
      if (i >= got.size() || got[i] !== exp_w[i]) begin
        errors++; $display("FAIL nominal_word%0d got %0h want %0h", i, (i < got.size()) ? got[i] : 32'hX, exp_w[i]);
      end
    end
    vectors++;
    if (first_valid != 5 || resp_cyc != 8) begin
      errors++; $display("FAIL nominal_latency got first=%0d resp=%0d want 5 8", first_valid, resp_cyc);
    end
  endtask

  task automatic test_bad_len();
    logic [31:0] lens[2];
    lens[0] = HEADER_BYTES + 8 * (MAXC + 1);
    lens[1] = HEADER_BYTES + 12;
    foreach (lens[k]) begin
      rand_pairs(0);
      model(lens[k]);
      send(lens[k], 0);
      collect(0, 0, 20);
      vectors++;
      if (r_code !== exp_code || r_count !== CW'(exp_cnt) || first_valid != -1 || resp_cyc != 2) begin
        errors++;
        $display("FAIL bad_len%0d got %0h/%0d first=%0d resp=%0d want %0h/%0d first=-1 resp=2",
                 k, r_code, r_count, first_valid, resp_cyc, exp_code, exp_cnt);
      end
    end
  endtask

  task automatic test_bad_payload();
    rand_pairs(0);
    bk[2] = 16;
    vl[2] = 5;
    model(HEADER_BYTES + 32);
    send(HEADER_BYTES + 32, 0);
    collect(0, 0, 30);
    vectors++;
    if (r_code !== exp_code || r_count !== CW'(exp_cnt) || got.size() != 0) begin
      errors++; $display("FAIL bad_payload got %0h/%0d beats=%0d want %0h/%0d beats=0", r_code, r_count, got.size(), exp_code, exp_cnt);
    end
    vectors++;
    if (resp_cyc != 3 + exp_bad) begin
      errors++; $display("FAIL bad_payload_cycles got %0d want %0d", resp_cyc, 3 + exp_bad);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] tls[2];
    int want;
    tls[0] = 20;
    tls[1] = 0;
    foreach (tls[k]) begin
      rand_pairs(0);
      want = (tls[k] == 0) ? 1000 : int'(tls[k]);
      send(HEADER_BYTES + 16, tls[k]);
      collect(2, 0, 1200);
      vectors++;
      if (r_code !== EXE_ERROR || r_count !== CW'(1) || got.size() != 1) begin
        errors++; $display("FAIL timeout%0d_resp got %0h/%0d beats=%0d want %0h/1 beats=1", k, r_code, r_count, got.size(), EXE_ERROR);
      end
      vectors++;
      if (resp_cyc - last_hs - 1 != want) begin
        errors++; $display("FAIL timeout%0d_stall got %0d want %0d", k, resp_cyc - last_hs - 1, want);
      end
    end
  endtask

  task automatic test_random_ready();
    int idle_bad;
    repeat (3) begin
      rand_pairs(0);
      model(HEADER_BYTES + 8 * MAXC);
      send(HEADER_BYTES + 8 * MAXC, 0);
      collect(1, 6, 400);
      vectors++;
      if (r_code !== exp_code || r_count !== CW'(exp_cnt) || got.size() != exp_w.size()) begin
        errors++; $display("FAIL rr_resp got %0h/%0d beats=%0d want %0h/%0d beats=%0d", r_code, r_count, got.size(), exp_code, exp_cnt, exp_w.size());
      end
      foreach (exp_w[i]) begin
        vectors++;
        if (i >= got.size() || got[i] !== exp_w[i]) begin
          errors++; $display("FAIL rr_word%0d got %0h want %0h", i, (i < got.size()) ? got[i] : 32'hX, exp_w[i]);
        end
      end
      vectors++;
      if (stall_bad != 0 || ready_bad != 0) begin
        errors++; $display("FAIL rr_stall_ready got unstable=%0d busy_ready=%0d want 0 0", stall_bad, ready_bad);
      end
      idle_bad = 0;
      repeat (15) begin
        @(posedge clk);
        #1;
        if (resp_valid || aso_cmd_valid || !task_ready || resp !== exp_code) idle_bad++;
      end
      vectors++;
      if (idle_bad != 0) begin
        errors++; $display("FAIL rr_ignored_poke got %0d bad idle cycles want 0", idle_bad);
      end
    end
  endtask

  task automatic test_random();
    int n, kind, mode;
    logic [31:0] len;
    repeat (16) begin
      n = $urandom_range(1, MAXC);
      kind = $urandom_range(0, 5);
      mode = $urandom_range(0, 1);
      len = HEADER_BYTES + 8 * n;
      if (kind == 0) len = len + $urandom_range(1, 7);
      if (kind == 1) len = $urandom_range(0, HEADER_BYTES);
      rand_pairs(8);
      model(len);
      send(len, 0);
      collect(mode, 0, 400);
      vectors++;
      if (r_code !== exp_code || r_count !== CW'(exp_cnt) || got.size() != exp_w.size()) begin
        errors++; $display("FAIL rand_resp len=%0d got %0h/%0d beats=%0d want %0h/%0d beats=%0d", len, r_code, r_count, got.size(), exp_code, exp_cnt, exp_w.size());
      end
      foreach (exp_w[i]) begin
        vectors++;
        if (i >= got.size() || got[i] !== exp_w[i]) begin
          errors++; $display("FAIL rand_word%0d got %0h want %0h", i, (i < got.size()) ? got[i] : 32'hX, exp_w[i]);
        end
      end
      if (mode == 0 && exp_code == TASK_VALID) begin
        vectors++;
        if (first_valid != exp_cnt + 2) begin
          errors++; $display("FAIL rand_latency got %0d want %0d", first_valid, exp_cnt + 2);
        end
      end
    end
  endtask

  task automatic test_rst_mid();
    int after_bad;
    rand_pairs(0);
    send(HEADER_BYTES + 32, 0);
    aso_cmd_ready = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    vectors++;
    if (aso_cmd_valid !== 1'b1) begin
      errors++; $display("FAIL rst_mid_in_src got valid=%0b want 1", aso_cmd_valid);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({task_ready, resp_valid, resp, resp_count, aso_cmd_valid, aso_cmd_data} !== {1'b1, 1'b0, 32'd0, CW'(0), 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL rst_mid_values got rdy=%0b rv=%0b resp=%0h cnt=%0d v=%0b d=%0h, want 1 0 0 0 0 0",
               task_ready, resp_valid, resp, resp_count, aso_cmd_valid, aso_cmd_data);
    end
    @(negedge clk);
    rst = 1'b0;
    after_bad = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (resp_valid || aso_cmd_valid || !task_ready) after_bad++;
    end
    vectors++;
    if (after_bad != 0) begin
      errors++; $display("FAIL rst_mid_no_resp got %0d bad cycles want 0", after_bad);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bad_len();
    test_bad_payload();
    test_timeout();
    test_random_ready();
    test_random();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/bank_cmd_multi.md
Name: bank_cmd_multi

Overview:
Parametrised successor of the single-shot bank command handler. It accepts a bank task carrying 1..MAX_CMDS (bank, value) pairs. It checks the task length and every pair, then streams one command word per pair on the aso_cmd source. It issues exactly one response per accepted task. New over the previous generation: a task_ready backpressure signal, a runtime timeout, and a resp_count output.

Parameters:
MAX_CMDS, 8, maximum number of (bank, value) pairs per task (1..16)
BANK_MAX, 15, largest legal bank index (inclusive)
VAL_MAX, 255, largest legal bank value (inclusive)
DEFAULT_TIMEOUT, 1000, stall limit in clk cycles, used when timeout_limit = 0
GAP_CYCLES, 4, idle cycles between command beats; used only with BANK_CMD_GAP_EN

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
task_valid  in  1  task strobe
task_ready  out  1  high only in IDLE; a task is accepted when task_valid & task_ready
len_bytes  in  32  task length in bytes, header included
bank_flat  in  32*MAX_CMDS  bank index of pair i at bits [32i+31:32i]
val_flat  in  32*MAX_CMDS  value of pair i, same packing as bank_flat
timeout_limit  in  32  per-task stall limit; 0 selects DEFAULT_TIMEOUT
resp_valid  out  1  one-cycle response strobe
resp  out  32  response code from task_icd_pkg
resp_count  out  $clog2(MAX_CMDS+1)  number of command beats completed for this task
aso_cmd_ready  in  1  sink ready
aso_cmd_valid  out  1  command valid
aso_cmd_data  out  32  command word

Behaviour:
- Reset values: task_ready=1, resp_valid=0, resp=0, resp_count=0, aso_cmd_valid=0, aso_cmd_data=0, state IDLE.
- Reset asserted mid-task: the task is abandoned and no response is issued.
- All outputs are registered.
- States: IDLE, VALIDATE_LEN, VALIDATE_PAYLOAD, SRC; GAP exists only with the macro.
- IDLE:
  - On acceptance, register len_bytes, all pairs and timeout_limit (0 is replaced by DEFAULT_TIMEOUT).
  - Go to VALIDATE_LEN; task_ready drops the next cycle.
- VALIDATE_LEN (1 cycle):
  - Legal lengths: len = HEADER_BYTES + 8*n, with 1 <= n <= MAX_CMDS. Compare using 32-bit unsigned arithmetic.
  - Legal length: n becomes the command limit; go to VALIDATE_PAYLOAD.
  - Illegal length: resp=HEADER_INVALID, resp_count=0, return to IDLE.
- VALIDATE_PAYLOAD:
  - Checks one pair per cycle, indices 0..n-1.
  - The first pair with bank > BANK_MAX or val > VAL_MAX gives resp=PAYLOAD_INVALID, resp_count=0, return to IDLE. No later pair is checked.
  - After pair n-1 passes, go to SRC with index=0 and the timeout counter cleared.
- Command word: cmd_icd_pkg::task2bank_cmd(bank[3:0], val[7:0]).
- SRC:
  - aso_cmd_valid rises on the first SRC cycle, carrying word 0.
  - aso_cmd_data is held stable while valid=1 and ready=0.
  - A beat completes on a clk edge with valid & ready. The next word is then presented on the following cycle with no bubble.
  - After beat n-1, valid drops and the block issues resp=TASK_VALID, resp_count=n, and returns to IDLE.
- Timeout:
  - The counter increments on every SRC cycle that has valid=1 and no handshake, and clears on each handshake.
  - When the counter equals the limit: valid drops, resp=EXE_ERROR, resp_count = beats completed so far, return to IDLE.
  - A handshake in the same cycle as the limit is reached wins; no timeout is raised.
- resp_valid pulses for exactly 1 cycle, in the same cycle the state becomes IDLE. resp and resp_count hold their values until the next response.
- task_ready returns high in that same cycle.
- A task_valid asserted while task_ready=0 is ignored; it is neither queued nor answered.
- Minimum accept-to-first-valid latency: 2 + n cycles.

Optional Feature:
BANK_CMD_GAP_EN
- Defined: after each completed beat except the last, aso_cmd_valid stays low for GAP_CYCLES cycles in state GAP, then the next word is presented. The timeout counter is frozen during GAP.
- Undefined: the GAP state and its counter are not compiled; beats run back-to-back.

Decomposition:
- cmd_icd_pkg: task2bank_cmd, unchanged.
- task_icd_pkg: HEADER_BYTES, the response codes, and a new constant BANK_CMD_WORDS = 2.
- The state enum stays local to the module.
- Sub-module bank_cmd_validator is natural: it holds the length decode and the per-index range check, and outputs the command limit and the first bad index.

Test Plan:
- n=3, len=HEADER_BYTES+24, pairs (1,10),(2,20),(15,255), ready=1 -> 3 back-to-back beats matching task2bank_cmd, then resp=TASK_VALID and resp_count=3; first valid appears 5 cycles after acceptance.
- len=HEADER_BYTES+8*(MAX_CMDS+1), and separately len=HEADER_BYTES+12 -> HEADER_INVALID, resp_count=0, no aso_cmd_valid.
- n=4 with pair 2 = (16,5) -> PAYLOAD_INVALID after exactly 3 payload-check cycles, no beats.
- n=2, timeout_limit=20, ready held low after beat 0 -> EXE_ERROR and resp_count=1 exactly 20 stalled cycles after beat 0; timeout_limit=0 -> DEFAULT_TIMEOUT is used.
- Random ready toggling with n=MAX_CMDS -> data is stable under stall and every word is delivered in order; task_valid pulsed mid-task is ignored, with task_ready=0.
- rst asserted during SRC -> all outputs go to their reset values immediately, and no resp_valid follows.
